// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring-divide unit holding architectural HI/LO registers.
// Optional build macro MULDIV_EARLY_OUT_EN lets multiplies finish once the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, fix_prod;
    logic               mul_last;

    assign mag_a = (op[0] && A[WIDTH-1]) ? -A : A;
    assign mag_b = (op[0] && B[WIDTH-1]) ? -B : B;

    // acc_hi/acc_lo are shared: product halves for multiply, remainder/quotient for divide
    assign add_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0] mrem_q, mrem_d;

    assign mul_last = !is_div_q && (mrem_q[WIDTH-1:1] == '0);
    // an early exit leaves cnt_q iterations of pure shifting still owed to the product
    assign prod     = {acc_hi_q, acc_lo_q} >> cnt_q;

    always_comb begin
        mrem_d = mrem_q;
        if (state_q == IDLE && start) begin
            mrem_d = mag_b;
        end else if (state_q == RUN) begin
            mrem_d = mrem_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mrem_q <= '0;
        end else begin
            mrem_q <= mrem_d;
        end
    end
`else
    assign mul_last = 1'b0;
    assign prod     = {acc_hi_q, acc_lo_q};
`endif

    assign fix_prod = neg_res_q ? -prod : prod;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = CW'(WIDTH - 1);
                    is_div_d  = op[1];
                    opnd_d    = op[1] ? mag_b : mag_a;
                    acc_hi_d  = '0;
                    acc_lo_d  = op[1] ? mag_a : mag_b;
                    // a zero divisor keeps the all-ones quotient unnegated
                    neg_res_d = op[0] && (A[WIDTH-1] ^ B[WIDTH-1]) && (!op[1] || (B != '0));
                    neg_rem_d = op[0] && A[WIDTH-1];
`ifdef MULDIV_EARLY_OUT_EN
                    if (!op[1] && (B == '0)) begin
                        state_d = FIX;
                        cnt_d   = CW'(WIDTH);
                    end
`endif
                end else begin
                    if (hi_we) begin
                        hi_d = wdata;
                    end
                    if (lo_we) begin
                        lo_d = wdata;
                    end
                end
            end
            RUN: begin
                if (is_div_q) begin
                    if (div_ge) begin
                        acc_hi_d = div_diff;
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = add_sum[WIDTH:1];
                    acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                if ((cnt_q == '0) || mul_last) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
                    lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
                end else begin
                    hi_d = fix_prod[2*WIDTH-1:WIDTH];
                    lo_d = fix_prod[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a cycle-level behavioural model of HI/LO/busy/done checked every cycle,
// plus directed operations with hand-computed results and randomized traffic.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] HI, LO;

    int errors = 0;
    int checks = 0;

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_pend = '0;
    int          m_left = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // architectural result of one operation as {HI, LO}
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        longint      p;
        int          sa, sb;
        logic [31:0] q, rm;
        sa = a;
        sb = b;
        case (o)
            2'd0: r = {32'h0, a} * {32'h0, b};
            2'd1: begin
                p = longint'(sa) * longint'(sb);
                r = p;
            end
            2'd2: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else        r = {a % b, a / b};
            end
            default: begin
                if (b == 0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = {32'h0, 32'h8000_0000};
                end else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm, q};
                end
            end
        endcase
        return r;
    endfunction

    // every op keeps the unit busy for 33 cycles, then shows its result with done
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                end
                m_left <= m_left - 1;
            end else if (start) begin
                m_pend <= ref_result(op, A, B);
                m_busy <= 1'b1;
                m_left <= 33;
            end else begin
                if (hi_we) m_hi <= wdata;
                if (lo_we) m_lo <= wdata;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check_output("busy", {31'b0, busy}, {31'b0, m_busy});
        check_output("done", {31'b0, done}, {31'b0, m_done});
        check_output("HI", HI, m_hi);
        check_output("LO", LO, m_lo);
    end

    task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input bit disturb, output int lat, output int busy_cycles);
        @(posedge clk); #1;
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); A = $urandom; B = $urandom;
        lat = 1;
        busy_cycles = busy ? 1 : 0;
        while (!done && lat < 100) begin
            if (disturb) begin
                hi_we = (lat == 10);
                wdata = 32'hDEAD_BEEF;
                start = (lat == 12);
                op    = 2'd1;
                A     = 32'h0000_0055;
                B     = 32'h0000_0003;
            end
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cycles++;
        end
        start = 1'b0;
        hi_we = 1'b0;
    endtask

    task automatic run_directed(input string name, input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                input bit disturb);
        int lat, bc;
        apply_stimulus(o, a, b, disturb, lat, bc);
        check_output({name, " HI"}, HI, exp_hi);
        check_output({name, " LO"}, LO, exp_lo);
        check_output({name, " model HI"}, m_hi, exp_hi);
        check_output({name, " model LO"}, m_lo, exp_lo);
        check_output({name, " latency"}, 32'(lat), 32'd34);
        check_output({name, " busy cycles"}, 32'(bc), 32'd33);
        check_output({name, " done"}, {31'b0, done}, 32'd1);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_output({name, " done seen"}, {31'b0, done}, 32'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dones;
        #2 rst_n = 1'b0;
        #1;
        check_output("reset busy", {31'b0, busy}, 32'd0);
        check_output("reset HI", HI, 32'd0);
        check_output("reset LO", LO, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // direct HI/LO writes, and start winning over a coincident write
        @(posedge clk); #1 hi_we = 1'b1; wdata = 32'hCAFE_0001;
        @(posedge clk); #1 hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0BAD_0002;
        check_output("mthi HI", HI, 32'hCAFE_0001);
        @(posedge clk); #1 lo_we = 1'b0;
        check_output("mtlo LO", LO, 32'h0BAD_0002);
        check_output("mtlo HI kept", HI, 32'hCAFE_0001);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); #1 hi_we = 1'b0; lo_we = 1'b0;
        check_output("both HI", HI, 32'h1234_5678);
        check_output("both LO", LO, 32'h1234_5678);
        start = 1'b1; hi_we = 1'b1; op = 2'd0; A = 32'd2; B = 32'd3; wdata = 32'hFFFF_0000;
        @(posedge clk); #1 start = 1'b0; hi_we = 1'b0;
        check_output("start beats mthi HI", HI, 32'h1234_5678);
        check_output("start beats mthi busy", {31'b0, busy}, 32'd1);
        wait_done("multu 2*3");
        check_output("multu 2*3 HI", HI, 32'h0);
        check_output("multu 2*3 LO", LO, 32'h6);

        run_directed("multu 7*6", 2'd0, 32'd7, 32'd6, 32'h0, 32'h0000_002A, 1'b0);
        run_directed("mult -3*5", 2'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_directed("multu max*max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
        run_directed("div -7/2", 2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_directed("divu 5/0", 2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
        run_directed("div -8/0", 2'd3, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b0);
        run_directed("div min/-1", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run_directed("div 7/-2", 2'd3, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0);
        run_directed("divu 100/7", 2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_directed("busy ignores", 2'd0, 32'h0000_1234, 32'h10, 32'h0, 32'h0001_2340, 1'b1);

        // reset in the middle of an operation
        @(posedge clk); #1 start = 1'b1; op = 2'd0; A = 32'd9; B = 32'd9;
        @(posedge clk); #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_output("abort busy", {31'b0, busy}, 32'd0);
        check_output("abort done", {31'b0, done}, 32'd0);
        check_output("abort HI", HI, 32'd0);
        check_output("abort LO", LO, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst_n = 1'b1;
            if (done) dones++;
        end
        check_output("abort no done", 32'(dones), 32'd0);

        // randomized traffic, including start held high and writes during busy
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            op    = 2'($urandom);
            A     = pick_operand();
            B     = pick_operand();
            hi_we = ($urandom_range(0, 7) == 0);
            lo_we = ($urandom_range(0, 7) == 0);
            wdata = $urandom;
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
